// File: rtl/hs_pkg.sv
// Shared definitions for the valid/ready handshake chain: slice mode codes
// and the capacity helper used to size the occupancy counter.
package hs_pkg;

  localparam int MODE_FWD  = 0;  // data/valid registered, ready combinational
  localparam int MODE_SKID = 1;  // ready registered, data/valid combinational
  localparam int MODE_FULL = 2;  // everything registered, two entries per slice

  // Number of items a chain of `depth` slices in `mode` can hold.
  function automatic int cap(input int mode, input int depth);
    return (mode == MODE_FULL) ? 2 * depth : depth;
  endfunction

endpackage

// File: rtl/hs_slice.sv
// One valid/ready handshake slice. MODE picks one of three register
// arrangements at elaboration; all share the same port contract.
module hs_slice
  import hs_pkg::*;
#(
  parameter int L    = 8,
  parameter int MODE = MODE_FWD
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         valid_up_i,
  output logic         ready_up_o,
  input  logic [L-1:0] data_up_i,
  output logic         valid_dn_o,
  input  logic         ready_dn_i,
  output logic [L-1:0] data_dn_o
);

  generate
    if (MODE == MODE_FWD) begin : g_fwd
      logic         v_q, v_d;
      logic [L-1:0] d_q, d_d;

      // A slot frees up whenever the downstream side takes the held item.
      assign ready_up_o = ready_dn_i | ~v_q;
      assign valid_dn_o = v_q;
      assign data_dn_o  = d_q;

      // Next state: a new item overwrites the slot; otherwise a drain empties it.
      always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
          v_d = 1'b0;
        end else if (valid_up_i && ready_up_o) begin
          v_d = 1'b1;
          d_d = data_up_i;
        end else if (ready_dn_i) begin
          v_d = 1'b0;
        end
      end

      // Slot register.
      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= 1'b0;
          d_q <= '0;
        end else begin
          v_q <= v_d;
          d_q <= d_d;
        end
      end
    end else if (MODE == MODE_SKID) begin : g_skid
      logic         sv_q, sv_d;
      logic [L-1:0] sd_q, sd_d;

      // Upstream only sees the registered skid state, never ready_dn_i.
      assign ready_up_o = ~sv_q;
      assign valid_dn_o = valid_up_i | sv_q;
      assign data_dn_o  = sv_q ? sd_q : data_up_i;

      // Next state: park an item that downstream refused, release it once taken.
      always_comb begin
        sv_d = sv_q;
        sd_d = sd_q;
        if (flush_i) begin
          sv_d = 1'b0;
        end else if (valid_up_i && ready_up_o && !ready_dn_i) begin
          sv_d = 1'b1;
          sd_d = data_up_i;
        end else if (sv_q && ready_dn_i) begin
          sv_d = 1'b0;
        end
      end

      // Skid register.
      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          sv_q <= 1'b0;
          sd_q <= '0;
        end else begin
          sv_q <= sv_d;
          sd_q <= sd_d;
        end
      end
    end else begin : g_full
      logic         mv_q, mv_d, sv_q, sv_d;
      logic [L-1:0] md_q, md_d, sd_q, sd_d;
      logic         up_xfer, dn_xfer;

      // Main entry feeds downstream; skid absorbs the item that arrives
      // while main is stalled, so ready can stay a pure register output.
      assign ready_up_o = ~sv_q;
      assign valid_dn_o = mv_q;
      assign data_dn_o  = md_q;
      assign up_xfer    = valid_up_i & ~sv_q;
      assign dn_xfer    = mv_q & ready_dn_i;

      // Next state: skid refills main first; new items go to main if it frees up.
      always_comb begin
        mv_d = mv_q;
        md_d = md_q;
        sv_d = sv_q;
        sd_d = sd_q;
        if (flush_i) begin
          mv_d = 1'b0;
          sv_d = 1'b0;
        end else if (sv_q) begin
          if (dn_xfer) begin
            md_d = sd_q;
            sv_d = 1'b0;
          end
        end else if (up_xfer && (!mv_q || dn_xfer)) begin
          mv_d = 1'b1;
          md_d = data_up_i;
        end else if (up_xfer) begin
          sv_d = 1'b1;
          sd_d = data_up_i;
        end else if (dn_xfer) begin
          mv_d = 1'b0;
        end
      end

      // Main and skid registers.
      always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
          mv_q <= 1'b0;
          md_q <= '0;
          sv_q <= 1'b0;
          sd_q <= '0;
        end else begin
          mv_q <= mv_d;
          md_q <= md_d;
          sv_q <= sv_d;
          sd_q <= sd_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/hs_pipe_chain.sv
// DEPTH handshake slices in series, with flush gating at both ends and an
// occupancy counter that tracks items between the upstream and downstream ports.
module hs_pipe_chain
  import hs_pkg::*;
#(
  parameter  int L     = 8,
  parameter  int DEPTH = 2,
  parameter  int MODE  = 0,
  localparam int CAP   = cap(MODE, DEPTH),
  localparam int OW    = $clog2(CAP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          valid_f,
  output logic          ready_f,
  input  logic [L-1:0]  data_f,
  output logic          valid_b,
  input  logic          ready_b,
  output logic [L-1:0]  data_b,
  output logic [OW-1:0] occupancy,
  output logic          empty,
  output logic          full
);

  // Link gi sits in front of slice gi; link DEPTH is the downstream port.
  logic         valid_w [DEPTH+1];
  logic         ready_w [DEPTH+1];
  logic [L-1:0] data_w  [DEPTH+1];

  logic          up_xfer, dn_xfer;
  logic [OW-1:0] occ_q, occ_d;

  // Flush blocks both ends so nothing enters or leaves during the discard.
  assign valid_w[0]     = valid_f & ~flush;
  assign data_w[0]      = data_f;
  assign ready_w[DEPTH] = ready_b & ~flush;

  assign ready_f = ready_w[0] & ~flush;
  assign valid_b = valid_w[DEPTH] & ~flush;
  // Zero the data bus while idle so stale or pass-through values never show.
  assign data_b  = valid_b ? data_w[DEPTH] : '0;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slice
      hs_slice #(
        .L    (L),
        .MODE (MODE)
      ) u_slice (
        .clk        (clk),
        .rst_ni     (rst),
        .flush_i    (flush),
        .valid_up_i (valid_w[gi]),
        .ready_up_o (ready_w[gi]),
        .data_up_i  (data_w[gi]),
        .valid_dn_o (valid_w[gi+1]),
        .ready_dn_i (ready_w[gi+1]),
        .data_dn_o  (data_w[gi+1])
      );
    end
  endgenerate

  assign up_xfer = valid_f & ready_f;
  assign dn_xfer = valid_b & ready_b;

  // Occupancy next state: count in on entry, out on exit, cleared by flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (up_xfer && !dn_xfer) begin
      occ_d = occ_q + OW'(1);
    end else if (!up_xfer && dn_xfer) begin
      occ_d = occ_q - OW'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
  assign empty     = (occ_q == '0);
  assign full      = (occ_q == OW'(CAP));

endmodule

// File: tb/tb_hs_pipe_chain.sv
// Directed bench for hs_pipe_chain: three instances (forward x3, skid x2,
// full x2) share one stimulus bus; each scenario observes the instance it targets.
module tb_hs_pipe_chain;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       valid_f = 1'b0;
  logic [7:0] data_f = 8'h00;
  logic       ready_b = 1'b0;

  logic       r0_ready_f, r0_valid_b, r0_empty, r0_full;
  logic [7:0] r0_data_b;
  logic [1:0] r0_occ;
  logic       r1_ready_f, r1_valid_b, r1_empty, r1_full;
  logic [7:0] r1_data_b;
  logic [1:0] r1_occ;
  logic       r2_ready_f, r2_valid_b, r2_empty, r2_full;
  logic [7:0] r2_data_b;
  logic [2:0] r2_occ;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hs_pipe_chain #(.L(8), .DEPTH(3), .MODE(0)) u_fwd (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_f(valid_f), .ready_f(r0_ready_f), .data_f(data_f),
    .valid_b(r0_valid_b), .ready_b(ready_b), .data_b(r0_data_b),
    .occupancy(r0_occ), .empty(r0_empty), .full(r0_full)
  );

  hs_pipe_chain #(.L(8), .DEPTH(2), .MODE(1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_f(valid_f), .ready_f(r1_ready_f), .data_f(data_f),
    .valid_b(r1_valid_b), .ready_b(ready_b), .data_b(r1_data_b),
    .occupancy(r1_occ), .empty(r1_empty), .full(r1_full)
  );

  hs_pipe_chain #(.L(8), .DEPTH(2), .MODE(2)) u_full (
    .clk(clk), .rst(rst), .flush(flush),
    .valid_f(valid_f), .ready_f(r2_ready_f), .data_f(data_f),
    .valid_b(r2_valid_b), .ready_b(ready_b), .data_b(r2_data_b),
    .occupancy(r2_occ), .empty(r2_empty), .full(r2_full)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  // Pulse reset and leave all inputs idle; returns on a falling clock edge.
  task automatic do_reset();
    @(negedge clk);
    flush = 1'b0; valid_f = 1'b0; data_f = 8'h00; ready_b = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    flush = 1'b0; valid_f = 1'b0; data_f = 8'h00; ready_b = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (r0_valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", r0_valid_b); end
    checks++; if (r0_ready_f !== 1'b1) begin errors++; $display("FAIL reset_ready_f: got %b want 1", r0_ready_f); end
    checks++; if (r0_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", r0_empty); end
    checks++; if (r0_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", r0_full); end
    checks++; if (r0_data_b !== 8'h00) begin errors++; $display("FAIL reset_data_b: got %h want 00", r0_data_b); end
    checks++; if (r0_occ !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", r0_occ); end
    checks++; if (r1_ready_f !== 1'b1 || r1_valid_b !== 1'b0) begin errors++; $display("FAIL reset_skid: ready_f=%b valid_b=%b want 1/0", r1_ready_f, r1_valid_b); end
    checks++; if (r2_ready_f !== 1'b1 || r2_valid_b !== 1'b0) begin errors++; $display("FAIL reset_fullslice: ready_f=%b valid_b=%b want 1/0", r2_ready_f, r2_valid_b); end
    $display("reset: valid_b=%b ready_f=%b empty=%b occ=%0d", r0_valid_b, r0_ready_f, r0_empty, r0_occ);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Forward chain, depth 3, sink always ready: 0x01..0x0A back to back.
  task automatic test_stream();
    int exp_occ;
    do_reset();
    ready_b = 1'b1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      exp_occ = ((j < 10) ? j : 10) - ((j > 3) ? j - 3 : 0);
      if (j >= 3 && j <= 12) begin
        checks++; if (r0_valid_b !== 1'b1 || r0_data_b !== 8'(j - 2)) begin errors++; $display("FAIL stream_out[%0d]: valid=%b data=%h want 1/%h", j, r0_valid_b, r0_data_b, 8'(j - 2)); end
        $display("stream: out %h at cycle %0d", r0_data_b, j);
      end else begin
        checks++; if (r0_valid_b !== 1'b0) begin errors++; $display("FAIL stream_idle[%0d]: valid=%b want 0", j, r0_valid_b); end
      end
      checks++; if (int'(r0_occ) !== exp_occ) begin errors++; $display("FAIL stream_occ[%0d]: got %0d want %0d", j, r0_occ, exp_occ); end
      checks++; if (r0_ready_f !== 1'b1) begin errors++; $display("FAIL stream_ready_f[%0d]: got %b want 1", j, r0_ready_f); end
      valid_f = (j < 10);
      data_f  = 8'(j + 1);
    end
    valid_f = 1'b0;
  endtask

  // Forward chain with the sink stalled: fills after three, then drains in order.
  task automatic test_fill_full();
    logic [7:0] exp_out [3];
    exp_out[0] = 8'h22; exp_out[1] = 8'h33; exp_out[2] = 8'h44;
    do_reset();
    ready_b = 1'b0;
    @(negedge clk);
    checks++; if (r0_ready_f !== 1'b1) begin errors++; $display("FAIL fill_ready0: got %b want 1", r0_ready_f); end
    valid_f = 1'b1; data_f = 8'h11;
    @(negedge clk);
    checks++; if (r0_ready_f !== 1'b1) begin errors++; $display("FAIL fill_ready1: got %b want 1", r0_ready_f); end
    data_f = 8'h22;
    @(negedge clk);
    checks++; if (r0_ready_f !== 1'b1) begin errors++; $display("FAIL fill_ready2: got %b want 1", r0_ready_f); end
    data_f = 8'h33;
    @(negedge clk);
    data_f = 8'h44;
    checks++; if (r0_ready_f !== 1'b0) begin errors++; $display("FAIL fill_ready3: got %b want 0", r0_ready_f); end
    checks++; if (r0_full !== 1'b1 || r0_occ !== 2'd3) begin errors++; $display("FAIL fill_full: full=%b occ=%0d want 1/3", r0_full, r0_occ); end
    checks++; if (r0_valid_b !== 1'b1 || r0_data_b !== 8'h11) begin errors++; $display("FAIL fill_head: valid=%b data=%h want 1/11", r0_valid_b, r0_data_b); end
    @(negedge clk);
    checks++; if (r0_ready_f !== 1'b0 || r0_occ !== 2'd3) begin errors++; $display("FAIL fill_hold: ready_f=%b occ=%0d want 0/3", r0_ready_f, r0_occ); end
    ready_b = 1'b1;
    #1;
    checks++; if (r0_ready_f !== 1'b1) begin errors++; $display("FAIL fill_recover: ready_f=%b want 1", r0_ready_f); end
    checks++; if (r0_data_b !== 8'h11) begin errors++; $display("FAIL fill_out0: got %h want 11", r0_data_b); end
    $display("fill: out %h", r0_data_b);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_f = 1'b0;
      checks++; if (r0_valid_b !== 1'b1 || r0_data_b !== exp_out[k]) begin errors++; $display("FAIL fill_out%0d: valid=%b data=%h want 1/%h", k + 1, r0_valid_b, r0_data_b, exp_out[k]); end
      checks++; if (int'(r0_occ) !== 3 - k) begin errors++; $display("FAIL fill_drain_occ%0d: got %0d want %0d", k, r0_occ, 3 - k); end
      $display("fill: out %h", r0_data_b);
    end
    @(negedge clk);
    checks++; if (r0_valid_b !== 1'b0 || r0_empty !== 1'b1) begin errors++; $display("FAIL fill_end: valid=%b empty=%b want 0/1", r0_valid_b, r0_empty); end
  endtask

  // Skid chain with toggling sink and random source against a queue model.
  task automatic test_skid_random();
    logic [7:0] q [$];
    logic [7:0] exp_d;
    logic       pend, up, dn, rf;
    int         sent, rcvd, cyc;
    do_reset();
    pend = 1'b0; sent = 0; rcvd = 0; cyc = 0;
    ready_b = 1'b0;
    while (rcvd < 200 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      checks++; if (int'(r1_occ) !== q.size() || r1_occ > 2'd2) begin errors++; $display("FAIL skid_occ[%0d]: got %0d want %0d", cyc, r1_occ, q.size()); end
      checks++; if (r1_empty !== (q.size() == 0)) begin errors++; $display("FAIL skid_empty[%0d]: got %b want %b", cyc, r1_empty, q.size() == 0); end
      ready_b = ~ready_b;
      if (!pend) begin
        if (sent < 200 && $urandom_range(0, 1) == 1) begin
          valid_f = 1'b1;
          data_f  = 8'($urandom_range(0, 255));
        end else begin
          valid_f = 1'b0;
        end
      end
      #1;
      rf = r1_ready_f;
      ready_b = ~ready_b;
      #1;
      checks++; if (r1_ready_f !== rf) begin errors++; $display("FAIL skid_ready_path[%0d]: ready_f moved %b->%b with ready_b", cyc, rf, r1_ready_f); end
      ready_b = ~ready_b;
      #1;
      up = valid_f & r1_ready_f;
      dn = r1_valid_b & ready_b;
      if (up) begin
        q.push_back(data_f);
        sent++;
      end
      if (dn) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL skid_extra[%0d]: output %h with nothing outstanding", cyc, r1_data_b);
        end else begin
          exp_d = q.pop_front();
          checks++; if (r1_data_b !== exp_d) begin errors++; $display("FAIL skid_data[%0d]: got %h want %h", rcvd, r1_data_b, exp_d); end
          $display("skid: item %0d out %h", rcvd, r1_data_b);
        end
        rcvd++;
      end
      pend = valid_f & ~up;
    end
    checks++; if (rcvd != 200) begin errors++; $display("FAIL skid_count: got %0d want 200 within budget", rcvd); end
    valid_f = 1'b0;
  endtask

  // Full-slice chain, depth 2, stalled sink: holds four, then drains in order.
  task automatic test_full_slice();
    logic [7:0] items [4];
    logic       acc;
    int         idx, n;
    items[0] = 8'hA1; items[1] = 8'hB2; items[2] = 8'hC3; items[3] = 8'hD4;
    do_reset();
    ready_b = 1'b0; acc = 1'b0; idx = 0; n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (acc) idx++;
      checks++; if (r2_ready_f !== (k < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b want %b", k, r2_ready_f, k < 4); end
      if (idx < 4) begin
        valid_f = 1'b1;
        data_f  = items[idx];
      end else begin
        valid_f = 1'b0;
      end
      #1;
      acc = valid_f & r2_ready_f;
    end
    checks++; if (r2_occ !== 3'd4 || r2_full !== 1'b1) begin errors++; $display("FAIL full_occ: occ=%0d full=%b want 4/1", r2_occ, r2_full); end
    ready_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (r2_valid_b) begin
        if (n < 4) begin
          checks++; if (r2_data_b !== items[n]) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", n, r2_data_b, items[n]); end
          $display("full: out %h", r2_data_b);
        end else begin
          checks++; errors++;
          $display("FAIL full_extra: output %h after all four delivered", r2_data_b);
        end
        n++;
      end
      @(negedge clk);
    end
    checks++; if (n != 4) begin errors++; $display("FAIL full_count: got %0d want 4", n); end
    checks++; if (r2_empty !== 1'b1) begin errors++; $display("FAIL full_empty: got %b want 1", r2_empty); end
  endtask

  // Flush with three held items and 0x55 offered concurrently.
  task automatic test_flush();
    do_reset();
    ready_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_f = 1'b1;
      data_f  = 8'(k + 1);
    end
    @(negedge clk);
    checks++; if (r0_occ !== 2'd3 || r2_occ !== 3'd3) begin errors++; $display("FAIL flush_pre_occ: fwd=%0d full=%0d want 3/3", r0_occ, r2_occ); end
    flush = 1'b1; valid_f = 1'b1; data_f = 8'h55;
    #1;
    checks++; if (r0_ready_f !== 1'b0 || r0_valid_b !== 1'b0) begin errors++; $display("FAIL flush_gate_fwd: ready_f=%b valid_b=%b want 0/0", r0_ready_f, r0_valid_b); end
    checks++; if (r2_ready_f !== 1'b0 || r2_valid_b !== 1'b0) begin errors++; $display("FAIL flush_gate_full: ready_f=%b valid_b=%b want 0/0", r2_ready_f, r2_valid_b); end
    @(negedge clk);
    flush = 1'b0; valid_f = 1'b0;
    checks++; if (r0_occ !== 2'd0 || r0_empty !== 1'b1) begin errors++; $display("FAIL flush_fwd_clear: occ=%0d empty=%b want 0/1", r0_occ, r0_empty); end
    checks++; if (r2_occ !== 3'd0 || r2_empty !== 1'b1) begin errors++; $display("FAIL flush_full_clear: occ=%0d empty=%b want 0/1", r2_occ, r2_empty); end
    ready_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (r0_valid_b !== 1'b0 || r2_valid_b !== 1'b0) begin errors++; $display("FAIL flush_leak[%0d]: fwd valid=%b data=%h full valid=%b data=%h want no output", k, r0_valid_b, r0_data_b, r2_valid_b, r2_data_b); end
      @(negedge clk);
    end
    $display("flush: chains empty, nothing delivered");
  endtask

  // Asynchronous reset in the middle of a stream, then one clean item.
  task automatic test_reset_midstream();
    int  wait_cyc;
    logic seen;
    do_reset();
    ready_b = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      valid_f = 1'b1;
      data_f  = 8'h61 + 8'(k);
    end
    @(negedge clk);
    valid_f = 1'b0;
    checks++; if (r0_occ !== 2'd3 || r0_valid_b !== 1'b1) begin errors++; $display("FAIL midrst_pre: occ=%0d valid_b=%b want 3/1", r0_occ, r0_valid_b); end
    #2 rst = 1'b0;
    #1;
    checks++; if (r0_valid_b !== 1'b0 || r0_occ !== 2'd0) begin errors++; $display("FAIL midrst_async: valid_b=%b occ=%0d want 0/0", r0_valid_b, r0_occ); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    valid_f = 1'b1; data_f = 8'hA5;
    @(negedge clk);
    valid_f = 1'b0; data_f = 8'h00;
    wait_cyc = 0; seen = 1'b0;
    while (!seen && wait_cyc < 10) begin
      #1;
      if (r0_valid_b) begin
        seen = 1'b1;
        checks++; if (r0_data_b !== 8'hA5) begin errors++; $display("FAIL midrst_data: got %h want a5", r0_data_b); end
        $display("midrst: out %h", r0_data_b);
      end
      @(negedge clk);
      wait_cyc++;
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_timeout: no output within 10 cycles"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill_full();
    test_skid_random();
    test_full_slice();
    test_flush();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hs_pipe_chain.md
Name: hs_pipe_chain

Overview:
- Parametrised valid/ready register chain: DEPTH identical handshake slices between an upstream master and a downstream slave.
- Successor to the hand-wired forward-pipe / backward-skid-buffer pairing. Every slice runs in one selectable MODE: forward register, backward skid, or full (both paths registered).
- Adds synchronous flush, an occupancy counter and empty/full flags for bench observation and back-pressure debug.

Parameters:
- L, 8, data width in bits.
- DEPTH, 2, number of slices (1..8).
- MODE, 0, 0 = forward pipe (data/valid registered); 1 = backward skid (ready registered); 2 = full slice (data, valid and ready all registered, 2 entries).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all held data.
- valid_f  in  1  upstream valid.
- ready_f  out  1  upstream ready.
- data_f  in  L  upstream data.
- valid_b  out  1  downstream valid.
- ready_b  in  1  downstream ready.
- data_b  out  L  downstream data.
- occupancy  out  $clog2(CAP+1)  items held. CAP = DEPTH for MODE 0/1, 2*DEPTH for MODE 2.
- empty  out  1  occupancy == 0.
- full  out  1  occupancy == CAP.

Behaviour:
- Transfer rule: a transfer occurs at a rising edge where valid and ready are both 1. A producer must not drop valid or change data until its transfer occurs.
- Reset (rst low, asynchronous):
  - All slice valid and skid-valid bits cleared; occupancy = 0.
  - Outputs: valid_b = 0, ready_f = 1, empty = 1, full = 0, data_b = 0.
- MODE 0, per slice:
  - ready_up = ready_dn | ~v.
  - On up-transfer: v <= 1, d <= data.
  - Else on down-transfer: v <= 0.
  - Latency 1 cycle per slice; throughput 1 item/cycle. The ready path is combinational through all slices.
- MODE 1, per slice:
  - ready_up = ~sv (registered).
  - valid_dn = valid_up | sv; data_dn = sv ? sd : data_up.
  - Up-transfer while ready_dn = 0: capture into skid (sv <= 1).
  - Down-transfer while sv = 1: sv <= 0.
  - Latency 0; the valid/data path is combinational.
- MODE 2, per slice:
  - Two-entry buffer (main + skid). ready_up = ~skid_full (registered); valid_dn = main_v (registered).
  - Latency 1 cycle per slice; full throughput with no combinational path.
- Chain:
  - Slice 0 connects to the _f ports, slice DEPTH-1 to the _b ports.
  - End-to-end latency is DEPTH cycles (MODE 0/2) or 0 cycles (MODE 1).
- Ordering: items leave in strict arrival order. No loss and no duplication under any valid_f/ready_b pattern.
- Occupancy:
  - +1 on upstream transfer, -1 on downstream transfer, unchanged when both occur in the same cycle.
  - Must never exceed CAP or go below 0.
- Flush:
  - While flush = 1, ready_f and valid_b are forced to 0 combinationally, so no transfers occur.
  - At the edge, all valid/skid bits and occupancy are cleared.
  - Flush takes priority over any concurrent transfer. The item in flight on data_f is not accepted.
- Full, MODE 0 with ready_b held low: ready_f = 0 once all DEPTH slices are valid. Ready recovers in the same cycle ready_b rises.
- Reset mid-stream: all held data is discarded immediately. After rst deasserts, the first accepted item appears at data_b unchanged.

Decomposition:
- Package hs_pkg:
  - MODE_FWD = 0, MODE_SKID = 1, MODE_FULL = 2.
  - Function cap(MODE, DEPTH).
- Sub-module hs_slice (params L, MODE): one slice holding the three mode implementations via generate. hs_pipe_chain instantiates DEPTH of them in a generate loop.
- Occupancy, empty/full and flush gating live in the top level.

Test Plan:
- MODE 0, DEPTH 3, ready_b = 1, stream 0x01..0x0A back-to-back -> 0x01 appears on data_b 3 cycles after acceptance; then one item per cycle, in order; occupancy steady at 3.
- MODE 0, DEPTH 3, ready_b = 0, push 0x11, 0x22, 0x33, 0x44 -> ready_f drops after the 3rd item; full = 1, occupancy = 3. Raising ready_b delivers 0x11, 0x22, 0x33, 0x44 in order.
- MODE 1, DEPTH 2, ready_b toggling every cycle, random valid_f over 200 items -> ready_f never combinationally depends on ready_b; scoreboard matches exactly; occupancy <= 2.
- MODE 2, DEPTH 2, ready_b = 0 -> 4 items accepted, then ready_f = 0 and occupancy = 4. Releasing ready_b drains all 4 in order.
- Any mode, flush asserted with occupancy = 3 while valid_f = 1 with 0x55 -> next cycle occupancy = 0, empty = 1, and 0x55 is never output.
- rst pulsed low mid-stream -> valid_b = 0 and occupancy = 0 asynchronously. The first post-reset item 0xA5 emerges intact.
